sevenseg_scan_decoder: RTL and testbench



---
 rtl/sevenseg_scan_decoder.sv | 188 ++++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the displayed hex value as a valid/ready frame.
// Optional decimal-point capture is enabled by defining SEVENSEG_SCAN_DP_EN.
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
`ifdef SEVENSEG_SCAN_DP_EN
  input  logic                    seg_dp_n,
  output logic [NUM_DIGITS-1:0]   out_dp,
`endif
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    ovr_clr
);

`ifdef SEVENSEG_SCAN_DP_EN
  localparam int SEG_W = 8;
  logic [SEG_W-1:0] seg_raw;
  assign seg_raw = {seg_dp_n, seg_n};
`else
  localparam int SEG_W = 7;
  logic [SEG_W-1:0] seg_raw;
  assign seg_raw = seg_n;
`endif

  localparam logic [7:0]            LAST    = 8'(STABLE_CYCLES - 2);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  logic [SEG_W-1:0]        seg_meta_reg, seg_sync_reg, seg_prev_reg;
  logic [NUM_DIGITS-1:0]   dig_meta_reg, dig_sync_reg, dig_prev_reg;
  logic [7:0]              count_reg, count_next;
  logic                    armed_reg, armed_next;
  logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
  state_t                  state_reg, state_next;
  logic [4*NUM_DIGITS-1:0] out_data_reg, out_data_next;
  logic [NUM_DIGITS-1:0]   out_err_reg, out_err_next;
  logic                    overrun_reg, overrun_next;

  logic [NUM_DIGITS-1:0]   dig_low, cap_en;
  logic                    one_low, same, capture, complete;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [4:0]              decoded;

  // {illegal, nibble}; anything outside the hex glyph set (blank included) reads as nibble 0.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    case (seg)
      7'h3F: glyph_decode = 5'h00;  7'h06: glyph_decode = 5'h01;
      7'h5B: glyph_decode = 5'h02;  7'h4F: glyph_decode = 5'h03;
      7'h66: glyph_decode = 5'h04;  7'h6D: glyph_decode = 5'h05;
      7'h7D: glyph_decode = 5'h06;  7'h07: glyph_decode = 5'h07;
      7'h7F: glyph_decode = 5'h08;  7'h6F: glyph_decode = 5'h09;
      7'h77: glyph_decode = 5'h0A;  7'h7C: glyph_decode = 5'h0B;
      7'h39: glyph_decode = 5'h0C;  7'h5E: glyph_decode = 5'h0D;
      7'h79: glyph_decode = 5'h0E;  7'h71: glyph_decode = 5'h0F;
      default: glyph_decode = 5'h10;
    endcase
  endfunction

  assign dig_low = ~dig_sync_reg;
  assign one_low = (dig_low != '0) && ((dig_low & (dig_low - DIG_ONE)) == '0);
  assign same    = (seg_sync_reg == seg_prev_reg) && (dig_sync_reg == dig_prev_reg);
  assign decoded = glyph_decode(~seg_sync_reg[6:0]);
  assign cap_en  = capture ? dig_low : '0;
  assign complete = &seen_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nib_reg;
    logic       err_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        nib_reg <= '0;
        err_reg <= 1'b0;
      end else if (cap_en[gi]) begin
        nib_reg <= decoded[3:0];
        err_reg <= decoded[4];
      end
    end
    assign shadow_data[4*gi +: 4] = nib_reg;
    assign shadow_err[gi]         = err_reg;
  end

`ifdef SEVENSEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp_reg, out_dp_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dp_reg <= '0;
      out_dp_reg    <= '0;
    end else begin
      shadow_dp_reg <= (shadow_dp_reg & ~cap_en) | (cap_en & {NUM_DIGITS{~seg_sync_reg[7]}});
      if (state_reg == COLLECT && complete)
        out_dp_reg <= shadow_dp_reg;
    end
  end
  assign out_dp = out_dp_reg;
`endif

  always_comb begin
    count_next    = count_reg;
    armed_next    = armed_reg;
    capture       = 1'b0;
    state_next    = state_reg;
    out_data_next = out_data_reg;
    out_err_next  = out_err_reg;
    overrun_next  = overrun_reg;

    // One capture per dwell: the counter parks once disarmed until the pattern changes.
    if (!same || !one_low) begin
      count_next = '0;
      armed_next = 1'b1;
    end else if (armed_reg) begin
      count_next = count_reg + 8'd1;
      if (count_reg == LAST) begin
        capture    = 1'b1;
        armed_next = 1'b0;
      end
    end

    if (ovr_clr)
      overrun_next = 1'b0;

    case (state_reg)
      COLLECT: begin
        if (complete) begin
          out_data_next = shadow_data;
          out_err_next  = shadow_err;
          state_next    = PRESENT;
        end
      end
      PRESENT: begin
        if (complete)
          overrun_next = 1'b1;
        if (out_ready)
          state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase

    seen_next = (complete ? '0 : seen_reg) | cap_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_meta_reg <= '1;
      seg_sync_reg <= '1;
      seg_prev_reg <= '1;
      dig_meta_reg <= '1;
      dig_sync_reg <= '1;
      dig_prev_reg <= '1;
      count_reg    <= '0;
      armed_reg    <= 1'b1;
      seen_reg     <= '0;
      state_reg    <= COLLECT;
      out_data_reg <= '0;
      out_err_reg  <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      seg_meta_reg <= seg_raw;
      seg_sync_reg <= seg_meta_reg;
      seg_prev_reg <= seg_sync_reg;
      dig_meta_reg <= dig_n;
      dig_sync_reg <= dig_meta_reg;
      dig_prev_reg <= dig_sync_reg;
      count_reg    <= count_next;
      armed_reg    <= armed_next;
      seen_reg     <= seen_next;
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      out_err_reg  <= out_err_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_err   = out_err_reg;
  assign out_valid = (state_reg == PRESENT);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8), default build without decimal point.
module tb_sevenseg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        ovr_clr;

  int vectors     = 0;
  int miscompares = 0;
  int accepts     = 0;
  int base;

  sevenseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_n(dig_n),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready)
      accepts <= accepts + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] glyph, input int n);
    dig_n = ~(4'b0001 << d);
    seg_n = ~glyph;
    tick(n);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    tick(2);
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seg_n = 7'h7F; dig_n = 4'hF; out_ready = 1'b0; ovr_clr = 1'b0;
    tick(3);
    check("reset_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    tick(100);
    check("idle_valid",   32'(out_valid), 32'h0);
    check("idle_data",    32'(out_data),  32'h0);
    check("idle_err",     32'(out_err),   32'h0);
    check("idle_overrun", 32'(overrun),   32'h0);

    // Basic scan: 0, 2, B, F with ready high; latency checked on the last digit.
    out_ready = 1'b1;
    base = accepts;
    show(0, 7'h3F, 20);
    show(1, 7'h5B, 20);
    show(2, 7'h7C, 20);
    dig_n = 4'b0111; seg_n = ~7'h71;
    tick(10);
    check("lat_before", 32'(out_valid), 32'h0);
    tick(1);
    check("lat_valid", 32'(out_valid), 32'h1);
    check("scan_data", 32'(out_data),  32'hFB20);
    check("scan_err",  32'(out_err),   32'h0);
    tick(1);
    check("scan_valid_drop", 32'(out_valid), 32'h0);
    tick(8);
    check("scan_one_pulse", 32'(accepts - base), 32'h1);
    check("scan_data_hold", 32'(out_data), 32'hFB20);

    // 7-cycle dwell broken by a no-select cycle must not capture digit 0.
    do_reset();
    out_ready = 1'b0;
    show(0, 7'h06, 7);
    dig_n = 4'hF;
    tick(1);
    show(1, 7'h66, 20);
    show(2, 7'h6D, 20);
    show(3, 7'h7D, 20);
    check("short_dwell_nocap", 32'(out_valid), 32'h0);
    show(0, 7'h06, 40);
    check("long_dwell_valid", 32'(out_valid), 32'h1);
    check("long_dwell_data",  32'(out_data),  32'h6541);
    show(1, 7'h66, 20);
    show(2, 7'h6D, 20);
    show(3, 7'h7D, 20);
    check("long_dwell_single", 32'(overrun),  32'h0);
    check("long_dwell_hold",   32'(out_data), 32'h6541);

    // Illegal glyph 49 on digit 1 and blank on digit 2.
    do_reset();
    show(0, 7'h4F, 20);
    show(1, 7'h49, 20);
    show(2, 7'h00, 20);
    show(3, 7'h79, 20);
    check("err_valid", 32'(out_valid), 32'h1);
    check("err_data",  32'(out_data),  32'hE003);
    check("err_flags", 32'(out_err),   32'h6);

    // Two frames without ready: first held, second discarded as overrun.
    do_reset();
    show(0, 7'h06, 20);
    show(1, 7'h5B, 20);
    show(2, 7'h4F, 20);
    show(3, 7'h66, 20);
    check("ovr_first_data", 32'(out_data), 32'h4321);
    check("ovr_first_flag", 32'(overrun),  32'h0);
    show(0, 7'h6D, 20);
    show(1, 7'h7D, 20);
    show(2, 7'h07, 20);
    show(3, 7'h7F, 20);
    check("ovr_held_data", 32'(out_data),  32'h4321);
    check("ovr_set",       32'(overrun),   32'h1);
    check("ovr_valid",     32'(out_valid), 32'h1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'h0);
    tick(5);
    check("ovr_stays_clear", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    tick(1);
    check("accept_drop",      32'(out_valid), 32'h0);
    check("accept_data_hold", 32'(out_data),  32'h4321);

    // Reset with three digits seen, then only digit 3: no frame.
    do_reset();
    base = accepts;
    show(0, 7'h06, 20);
    show(1, 7'h5B, 20);
    show(2, 7'h4F, 20);
    rst = 1'b1; seg_n = 7'h7F; dig_n = 4'hF;
    tick(1);
    rst = 1'b0;
    check("midrst_data",  32'(out_data),  32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    show(3, 7'h66, 30);
    check("midrst_noframe",   32'(out_valid),      32'h0);
    check("midrst_noaccepts", 32'(accepts - base), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
